// File: rtl/mips_pkg.sv
// Shared definitions for the MEM/WB pipeline slice: control bit positions,
// default memory sizing, FSM encoding and the MEM/WB register layout.
package mips_pkg;

    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam int MEM_LAT_DEF   = 2;
    localparam int MEM_WORDS_DEF = 256;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] read_data;
        logic [31:0] alu;
        logic [4:0]  dest;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM-facing inputs and MEM/WB-facing outputs of the memory stage.
interface mem_wb_stage_if;
    logic [2:0]  M_in;
    logic [1:0]  WB_in;
    logic [31:0] Alu_in;
    logic [31:0] Store_data;
    logic [4:0]  Dest_reg;
    logic        Stall;
    logic [1:0]  WB_out;
    logic [31:0] Read_data_reg;
    logic [31:0] Alu_outreg;
    logic [4:0]  Forwarding_out;

    modport master (
        output M_in, WB_in, Alu_in, Store_data, Dest_reg,
        input  Stall, WB_out, Read_data_reg, Alu_outreg, Forwarding_out
    );

    modport slave (
        input  M_in, WB_in, Alu_in, Store_data, Dest_reg,
        output Stall, WB_out, Read_data_reg, Alu_outreg, Forwarding_out
    );
endinterface

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read, so a read
// in the same cycle as a write returns the pre-write word.
module data_mem
    import mips_pkg::*;
#(
    parameter int WORDS = MEM_WORDS_DEF,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    // NOTE: storage is never reset (reset must preserve contents); the
    // declaration initialiser gives the zero power-up image instead.
    logic [31:0] r_mem [WORDS] = '{default: '0};

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with a fixed-latency data memory and the MEM/WB pipeline register.
// Each access stalls upstream for MEM_LAT cycles, then completes in one cycle.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int MEM_LAT   = MEM_LAT_DEF,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic           clock,
    input  logic           reset,
    mem_wb_stage_if.slave  bus
);

    localparam int         AW     = $clog2(MEM_WORDS);
    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    logic [0:0]    r_state;
    logic [2:0]    r_cnt;
    mem_wb_t       r_mwb;

    logic          w_read;
    logic          w_write;
    logic          w_access;
    logic          w_done;
    logic          w_pass;
    logic          w_we;
    logic          w_stall;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_rdata;
    logic          w_unused_branch;

    assign w_read          = bus.M_in[M_MEMREAD];
    assign w_write         = bus.M_in[M_MEMWRITE];
    assign w_unused_branch = bus.M_in[M_BRANCH];
    assign w_access        = w_read | w_write;
    assign w_addr          = bus.Alu_in[AW+1:2];

    assign w_done = (r_state == ST_BUSY) && (r_cnt == 3'd0);
    assign w_pass = ((r_state == ST_IDLE) && !w_access) || w_done;
    // Memory is only touched in the completing cycle, and reset aborts it.
    assign w_we   = !reset && w_done && w_write;

    always_comb begin
        w_stall = 1'b0;
        if (!reset) begin
            if (r_state == ST_IDLE) begin
                w_stall = w_access;
            end else begin
                w_stall = (r_cnt != 3'd0);
            end
        end
    end

    data_mem #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_data_mem (
        .clock   (clock),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (bus.Store_data),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mwb   <= '0;
        end else begin
            r_mwb <= '0;
            if (w_pass) begin
                r_mwb.wb        <= bus.WB_in;
                r_mwb.alu       <= bus.Alu_in;
                r_mwb.dest      <= bus.Dest_reg;
                r_mwb.read_data <= (w_done && w_read && !w_write) ? w_rdata : 32'h0;
            end

            if (r_state == ST_IDLE) begin
                if (w_access) begin
                    r_state <= ST_BUSY;
                    r_cnt   <= LAT_M1;
                end
            end else if (r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign bus.Stall          = w_stall;
    assign bus.WB_out         = r_mwb.wb;
    assign bus.Read_data_reg  = r_mwb.read_data;
    assign bus.Alu_outreg     = r_mwb.alu;
    assign bus.Forwarding_out = r_mwb.dest;

endmodule
